mips_mc_ctrl: RTL
=================

# mips_mc_ctrl

Multi-cycle control unit for the MIPS datapath: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks instead of decoding a whole instruction in one cycle. It supports a variable-latency memory through a ready handshake and keeps a retired-instruction counter. It sits between the instruction register and the shared-memory multi-cycle datapath: PC, IR, A/B, ALUOut and MDR registers, one memory, one ALU.

## Interface
Parameters:
- ALUOP_W, 3, width of alu_op; must be ≥3; codes are zero-extended.
- MEM_HANDSHAKE, 1, 1 = wait for mem_ready on memory states; 0 = mem_ready ignored (treated as 1).
- CNT_W, 32, width of retired counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26], from the IR register; stable from DECODE onward.
- func  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC load enable; branch condition is already resolved.
- pc_src  out  2  0 = ALU result (PC+4), 1 = ALUOut (branch target), 2 = jump target.
- ior_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- alu_op  out  ALUOP_W  ALU operation code.
- illegal  out  1  unsupported instruction seen in DECODE.
- state  out  4  current state code, for debug.
- retired  out  CNT_W  count of completed instructions.

## Operation
ALU codes:
- 0 = and, 1 = or, 2 = add, 3 = sub, 4 = xor, 5 = sltu, 6 = slt, 7 = nop.

R-type func decode:
- 100100 → 0; 100101 → 1; 100000 → 2; 100010 → 3; 100110 → 4; 101011 → 5; 101010 → 6.

Outputs are a function of the current state only, except these combinational terms:
- pc_write in BRANCH.
- ir_write and pc_write in FETCH.
- illegal in DECODE.
- Every strobe not listed for a state is 0, and every select not listed is 0.

States (code: outputs → next state):
- RST (0): all outputs 0 → FETCH.
- FETCH (1): mem_read=1, ior_d=0, alu_src_a=0, alu_src_b=1, alu_op=2, pc_src=0; ir_write = pc_write = rdy, where rdy = mem_ready or !MEM_HANDSHAKE → DECODE if rdy, else FETCH.
- DECODE (2): alu_src_a=0, alu_src_b=3, alu_op=2.
  - opcode 000000 with a valid func → EXEC.
  - opcode 100011 (lw) or 101011 (sw) → MEMADDR.
  - opcode 000100 (beq) or 000101 (bne) → BRANCH.
  - opcode 000010 (j) → JUMP.
  - opcode 001100, 001101, 001000, 001010 → IEXEC.
  - Anything else, including R-type with an unknown func: illegal=1 → FETCH.
- MEMADDR (3): alu_src_a=1, alu_src_b=2, alu_op=2 → MEMRD for lw, MEMWR for sw.
- MEMRD (4): mem_read=1, ior_d=1 → MEMWB on rdy, else hold.
- MEMWB (5): reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEMWR (6): mem_write=1, ior_d=1 → FETCH on rdy, else hold.
- EXEC (7): alu_src_a=1, alu_src_b=0, alu_op = func decode → RWB.
- RWB (8): reg_write=1, reg_dst=1, mem_to_reg=0, alu_op = func decode → FETCH.
- BRANCH (9): alu_src_a=1, alu_src_b=0, alu_op=3, pc_src=1; pc_write = (beq & zero) | (bne & !zero) → FETCH.
- JUMP (10): pc_src=2, pc_write=1 → FETCH.
- IEXEC (11): alu_src_a=1, alu_src_b=2; alu_op: andi → 0, ori → 1, addi → 2, slti → 6 → IWB.
- IWB (12): reg_write=1, reg_dst=0, mem_to_reg=0, alu_op held as in IEXEC → FETCH.
- Codes 13–15: all outputs 0 → RST.

Retired counter:
- Increments by 1 on the clock edge leaving MEMWB, RWB, BRANCH, JUMP or IWB, and on the edge leaving MEMWR with rdy.
- An illegal instruction does not count.
- Wraps modulo 2^CNT_W.

## Timing
- Reset (rst_n=0, asynchronous): state=RST, retired=0, all other outputs 0. FETCH is entered on the first rising edge after rst_n deasserts.
- Reset asserted mid-instruction aborts it immediately. No memory or register strobe stays high after rst_n falls.
- Cycles per instruction with zero-wait memory: R-type 4, I-type ALU 4, lw 5, sw 4, beq/bne 3, j 3, illegal 2.
- Each memory state adds one cycle per cycle that mem_ready=0. During a wait, every output holds its value and pc_write/ir_write stay 0.
- MEM_HANDSHAKE=0: no wait cycles. mem_ready may be X.
- A branch taken or not takes the same cycle count; only pc_write differs.

## Test plan
- Reset then add (opcode 0, func 100000), mem_ready=1 → states 1, 2, 7, 8, 1. alu_op=2 in EXEC; reg_write=1, reg_dst=1 in RWB; retired 0 → 1.
- lw with mem_ready low for 2 cycles in both FETCH and MEMRD → FETCH spans 3 cycles with ir_write=1 only in the last; MEMRD spans 3 cycles; 9 cycles total; mem_to_reg=1 in MEMWB.
- beq with zero=1, then beq with zero=0, then bne with zero=0 → pc_write in BRANCH is 1, 0, 1; pc_src=1; retired +3.
- Opcode 111111, then opcode 0 with func 000000 → illegal=1 for one DECODE cycle each, return to FETCH, no reg_write/mem_write, retired unchanged.
- slti then j → alu_op=6 in IEXEC/IWB with alu_src_b=2; JUMP has pc_src=2, pc_write=1.
- rst_n pulsed low during MEMWR, and separately MEM_HANDSHAKE=0 with mem_ready=0 → mem_write drops asynchronously and state=RST; with handshake off, lw completes in 5 cycles regardless of mem_ready.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback.
// It waits on a memory ready handshake and counts retired instructions.
module mips_mc_ctrl #(
    parameter int ALUOP_W       = 3,
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               ior_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal,
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADDR = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_IEXEC   = 4'd11,
        S_IWB     = 4'd12
    } state_t;

    typedef struct packed {
        logic [1:0] pc_src;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       jump;
    } ctl_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    state_t     state_q;
    state_t     nxt;
    ctl_t       ctl_q;
    logic       rdy;
    logic       r_valid;
    logic [2:0] r_op;
    logic       i_valid;
    logic [2:0] i_op;
    logic       legal;
    logic       take;
    logic       retire;

    function automatic ctl_t decode_ctl(input state_t s, input logic [2:0] rop, input logic [2:0] iop);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'd1;
                c.alu_op    = 3'd2;
            end
            S_DECODE: begin
                c.alu_src_b = 2'd3;
                c.alu_op    = 3'd2;
            end
            S_MEMADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
                c.alu_op    = 3'd2;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.ior_d     = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = rop;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.alu_op    = rop;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'd3;
                c.pc_src    = 2'd1;
            end
            S_JUMP: begin
                c.pc_src = 2'd2;
                c.jump   = 1'b1;
            end
            S_IEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
                c.alu_op    = iop;
            end
            S_IWB: begin
                c.reg_write = 1'b1;
                c.alu_op    = iop;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

        r_valid = 1'b1;
        r_op    = 3'd7;
        case (func)
            6'b100100: r_op = 3'd0;
            6'b100101: r_op = 3'd1;
            6'b100000: r_op = 3'd2;
            6'b100010: r_op = 3'd3;
            6'b100110: r_op = 3'd4;
            6'b101011: r_op = 3'd5;
            6'b101010: r_op = 3'd6;
            default:   r_valid = 1'b0;
        endcase

        i_valid = 1'b1;
        i_op    = 3'd7;
        case (opcode)
            OP_ANDI: i_op = 3'd0;
            OP_ORI:  i_op = 3'd1;
            OP_ADDI: i_op = 3'd2;
            OP_SLTI: i_op = 3'd6;
            default: i_valid = 1'b0;
        endcase

        legal = ((opcode == OP_R) && r_valid) || (opcode == OP_LW) || (opcode == OP_SW) ||
                (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_J) || i_valid;
        take  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);

        nxt = S_RST;
        case (state_q)
            S_RST:     nxt = S_FETCH;
            S_FETCH:   nxt = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((opcode == OP_R) && r_valid)                nxt = S_EXEC;
                else if ((opcode == OP_LW) || (opcode == OP_SW)) nxt = S_MEMADDR;
                else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) nxt = S_BRANCH;
                else if (opcode == OP_J)                        nxt = S_JUMP;
                else if (i_valid)                               nxt = S_IEXEC;
                else                                            nxt = S_FETCH;
            end
            S_MEMADDR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   nxt = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:   nxt = S_FETCH;
            S_MEMWR:   nxt = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:    nxt = S_RWB;
            S_RWB:     nxt = S_FETCH;
            S_BRANCH:  nxt = S_FETCH;
            S_JUMP:    nxt = S_FETCH;
            S_IEXEC:   nxt = S_IWB;
            S_IWB:     nxt = S_FETCH;
            default:   nxt = S_RST;
        endcase

        retire = (state_q inside {S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB}) ||
                 ((state_q == S_MEMWR) && rdy);
    end

    // Control outputs are registered from the decode of the state being entered, so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            ctl_q   <= '0;
            retired <= '0;
        end else begin
            state_q <= nxt;
            ctl_q   <= decode_ctl(nxt, r_op, i_op);
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    assign pc_write   = ((state_q == S_FETCH) && rdy) || ((state_q == S_BRANCH) && take) || ctl_q.jump;
    assign ir_write   = (state_q == S_FETCH) && rdy;
    assign illegal    = (state_q == S_DECODE) && !legal;
    assign pc_src     = ctl_q.pc_src;
    assign ior_d      = ctl_q.ior_d;
    assign mem_read   = ctl_q.mem_read;
    assign mem_write  = ctl_q.mem_write;
    assign reg_dst    = ctl_q.reg_dst;
    assign mem_to_reg = ctl_q.mem_to_reg;
    assign reg_write  = ctl_q.reg_write;
    assign alu_src_a  = ctl_q.alu_src_a;
    assign alu_src_b  = ctl_q.alu_src_b;
    assign alu_op     = ALUOP_W'(ctl_q.alu_op);
    assign state      = state_q;

endmodule
